// File: rtl/tl_wdt_pkg.sv
// rtl/tl_wdt_pkg.sv - shared constants and types for the multi-channel TileLink watchdog
package tl_wdt_pkg;

    localparam int REG_W = 3;

    localparam logic [REG_W-1:0] REG_CTRL    = 3'd0;
    localparam logic [REG_W-1:0] REG_PET     = 3'd1;
    localparam logic [REG_W-1:0] REG_BARK_LD = 3'd2;
    localparam logic [REG_W-1:0] REG_BITE_LD = 3'd3;
    localparam logic [REG_W-1:0] REG_COUNT   = 3'd4;
    localparam logic [REG_W-1:0] REG_STATUS  = 3'd5;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_BARK     = 2'd1,
        ST_BITE     = 2'd2,
        ST_EXPIRED  = 2'd3
    } wdt_state_e;

    // Each channel owns a 32-byte window; at least one channel-index bit is always present.
    function automatic int addr_width(input int noc);
        return ($clog2(noc) + 5 < 6) ? 6 : $clog2(noc) + 5;
    endfunction

endpackage

// File: rtl/tl_wdt_channel.sv
// rtl/tl_wdt_channel.sv - one two-stage (bark/bite) watchdog channel with its register bits
module tl_wdt_channel
    import tl_wdt_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_ctrl,
    input  logic             wr_pet,
    input  logic             wr_bark_ld,
    input  logic             wr_bite_ld,
    input  logic             wr_status,
    input  logic [31:0]      wdata,
    input  logic [REG_W-1:0] rd_reg,
    output logic [31:0]      rd_data,
    output logic             lock,
    output logic             irq,
    output logic             expired
);

    wdt_state_e       state;
    logic             en;
    logic             bark;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] bark_ld;
    logic [CNT_W-1:0] bite_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_DISABLED;
            en      <= 1'b0;
            lock    <= 1'b0;
            bark    <= 1'b0;
            cnt     <= '0;
            bark_ld <= '0;
            bite_ld <= '0;
        end else begin
            if (wr_ctrl) begin
                en   <= wdata[0];
                lock <= lock | wdata[1];
            end
            if (wr_bark_ld) bark_ld <= wdata[CNT_W-1:0];
            if (wr_bite_ld) bite_ld <= wdata[CNT_W-1:0];
            if (wr_status && wdata[0]) bark <= 1'b0;

            // A pet is checked before the zero test so it wins a same-cycle timeout.
            case (state)
                ST_DISABLED: begin
                    if (wr_ctrl && wdata[0]) begin
                        state <= ST_BARK;
                        cnt   <= bark_ld;
                    end
                end
                ST_BARK, ST_BITE: begin
                    if (wr_pet) begin
                        state <= ST_BARK;
                        cnt   <= bark_ld;
                        bark  <= 1'b0;
                    end else if (wr_ctrl && !wdata[0]) begin
                        state <= ST_DISABLED;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (state == ST_BARK) begin
                        state <= ST_BITE;
                        cnt   <= bite_ld;
                        bark  <= 1'b1;
                    end else begin
                        state <= ST_EXPIRED;
                    end
                end
                default: ;
            endcase
        end
    end

    assign irq     = bark;
    assign expired = (state == ST_EXPIRED);

    always_comb begin
        rd_data = 32'h0;
        case (rd_reg)
            REG_CTRL:    rd_data = {30'h0, lock, en};
            REG_BARK_LD: rd_data = 32'(bark_ld);
            REG_BITE_LD: rd_data = 32'(bite_ld);
            REG_COUNT:   rd_data = 32'(cnt);
            REG_STATUS:  rd_data = {30'h0, expired, bark};
            default:     rd_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/tl_multi_watchdog.sv
// rtl/tl_multi_watchdog.sv - TileLink-UL slave wrapping NOC bark/bite watchdog channels
module tl_multi_watchdog
    import tl_wdt_pkg::*;
#(
    parameter int          TL_RS   = 4,
    parameter int          TL_SZ   = 4,
    parameter int          NOC     = 2,
    parameter int          CNT_W   = 32,
    parameter logic [31:0] PET_KEY = 32'h5A5A_C0DE,
    localparam int         AW      = addr_width(NOC)
) (
    input  logic             wdt_clock_i,
    input  logic             wdt_reset_ni,
    input  logic [2:0]       wdt_a_opcode,
    input  logic [2:0]       wdt_a_param,
    input  logic [TL_SZ-1:0] wdt_a_size,
    input  logic [TL_RS-1:0] wdt_a_source,
    input  logic [AW-1:0]    wdt_a_address,
    input  logic [3:0]       wdt_a_mask,
    input  logic [31:0]      wdt_a_data,
    input  logic             wdt_a_corrupt,
    input  logic             wdt_a_valid,
    output logic             wdt_a_ready,
    output logic [2:0]       wdt_d_opcode,
    output logic [1:0]       wdt_d_param,
    output logic [TL_SZ-1:0] wdt_d_size,
    output logic [TL_RS-1:0] wdt_d_source,
    output logic             wdt_d_denied,
    output logic [31:0]      wdt_d_data,
    output logic             wdt_d_corrupt,
    output logic             wdt_d_valid,
    input  logic             wdt_d_ready,
    output logic [NOC-1:0]   irq_o,
    output logic             crm_o
);

    localparam int CH_W = AW - 5;

    logic [CH_W-1:0]  ch_idx;
    logic [REG_W-1:0] reg_idx;
    logic [NOC-1:0]   ch_sel;
    logic [NOC-1:0]   lock_vec;
    logic [NOC-1:0]   exp_vec;
    logic [31:0]      rd_vec [NOC];
    logic [31:0]      rd_sel;
    logic             accept, is_get, is_put, ch_ok, lock_sel, lock_deny, pet_deny, denied, wr_ok;
    logic             unused_a;

    assign unused_a = ^{wdt_a_param, wdt_a_corrupt, wdt_a_address[1:0]};

    assign ch_idx  = wdt_a_address[AW-1:5];
    assign reg_idx = wdt_a_address[4:2];
    assign accept  = wdt_a_valid & wdt_a_ready;
    assign is_get  = (wdt_a_opcode == TL_GET);
    assign is_put  = (wdt_a_opcode == TL_PUT_FULL) | (wdt_a_opcode == TL_PUT_PARTIAL);

    assign ch_ok    = |ch_sel;
    assign lock_sel = |(lock_vec & ch_sel);
    // A locked CTRL may still be written as long as the lock bit stays set, so en can toggle.
    assign lock_deny = lock_sel & (((reg_idx == REG_CTRL) & ~wdt_a_data[1]) |
                                   (reg_idx == REG_BARK_LD) | (reg_idx == REG_BITE_LD));
    assign pet_deny  = (reg_idx == REG_PET) & (wdt_a_data != PET_KEY);
    assign denied    = ~(is_get | is_put) | ~ch_ok |
                       (is_put & ((wdt_a_mask != 4'hF) | lock_deny | pet_deny));
    assign wr_ok     = accept & is_put & ~denied;

    always_comb begin
        rd_sel = 32'h0;
        for (int i = 0; i < NOC; i++) begin
            if (ch_sel[i]) rd_sel = rd_vec[i];
        end
    end

    for (genvar i = 0; i < NOC; i++) begin : g_ch
        assign ch_sel[i] = (ch_idx == CH_W'(i));

        tl_wdt_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (wdt_clock_i),
            .rst_n      (wdt_reset_ni),
            .wr_ctrl    (wr_ok & ch_sel[i] & (reg_idx == REG_CTRL)),
            .wr_pet     (wr_ok & ch_sel[i] & (reg_idx == REG_PET)),
            .wr_bark_ld (wr_ok & ch_sel[i] & (reg_idx == REG_BARK_LD)),
            .wr_bite_ld (wr_ok & ch_sel[i] & (reg_idx == REG_BITE_LD)),
            .wr_status  (wr_ok & ch_sel[i] & (reg_idx == REG_STATUS)),
            .wdata      (wdt_a_data),
            .rd_reg     (reg_idx),
            .rd_data    (rd_vec[i]),
            .lock       (lock_vec[i]),
            .irq        (irq_o[i]),
            .expired    (exp_vec[i])
        );
    end

    always_ff @(posedge wdt_clock_i or negedge wdt_reset_ni) begin
        if (!wdt_reset_ni) begin
            wdt_d_valid  <= 1'b0;
            wdt_d_opcode <= 3'h0;
            wdt_d_size   <= '0;
            wdt_d_source <= '0;
            wdt_d_denied <= 1'b0;
            wdt_d_data   <= 32'h0;
            crm_o        <= 1'b0;
        end else begin
            crm_o <= |exp_vec;
            if (accept) begin
                wdt_d_valid  <= 1'b1;
                wdt_d_opcode <= is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
                wdt_d_size   <= wdt_a_size;
                wdt_d_source <= wdt_a_source;
                wdt_d_denied <= denied;
                wdt_d_data   <= (is_get & ~denied) ? rd_sel : 32'h0;
            end else if (wdt_d_ready) begin
                wdt_d_valid <= 1'b0;
            end
        end
    end

    assign wdt_a_ready   = ~wdt_d_valid | wdt_d_ready;
    assign wdt_d_param   = 2'b00;
    assign wdt_d_corrupt = 1'b0;

endmodule

// File: tb/tb_tl_multi_watchdog.sv
// tb/tb_tl_multi_watchdog.sv - randomized self-checking bench for tl_multi_watchdog
module tb_tl_multi_watchdog;

    localparam int          NOC   = 3;
    localparam int          CNT_W = 16;
    localparam int          AW    = 7;
    localparam logic [31:0] KEY   = 32'h5A5A_C0DE;
    localparam logic [2:0]  R_CTRL = 3'd0, R_PET = 3'd1, R_BARK = 3'd2, R_BITE = 3'd3,
                            R_COUNT = 3'd4, R_STATUS = 3'd5, R_RSVD = 3'd6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     a_opcode = 3'h0, a_param = 3'h0;
    logic [3:0]     a_size = 4'h0, a_source = 4'h0, a_mask = 4'h0;
    logic [AW-1:0]  a_address = '0;
    logic [31:0]    a_data = 32'h0;
    logic           a_corrupt = 1'b0, a_valid = 1'b0, a_ready;
    logic [2:0]     d_opcode;
    logic [1:0]     d_param;
    logic [3:0]     d_size, d_source;
    logic           d_denied, d_corrupt, d_valid;
    logic           d_ready = 1'b1;
    logic [31:0]    d_data;
    logic [NOC-1:0] irq;
    logic           crm;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int ac;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tl_multi_watchdog #(.TL_RS(4), .TL_SZ(4), .NOC(NOC), .CNT_W(CNT_W), .PET_KEY(KEY)) dut (
        .wdt_clock_i   (clk),
        .wdt_reset_ni  (rst_n),
        .wdt_a_opcode  (a_opcode),
        .wdt_a_param   (a_param),
        .wdt_a_size    (a_size),
        .wdt_a_source  (a_source),
        .wdt_a_address (a_address),
        .wdt_a_mask    (a_mask),
        .wdt_a_data    (a_data),
        .wdt_a_corrupt (a_corrupt),
        .wdt_a_valid   (a_valid),
        .wdt_a_ready   (a_ready),
        .wdt_d_opcode  (d_opcode),
        .wdt_d_param   (d_param),
        .wdt_d_size    (d_size),
        .wdt_d_source  (d_source),
        .wdt_d_denied  (d_denied),
        .wdt_d_data    (d_data),
        .wdt_d_corrupt (d_corrupt),
        .wdt_d_valid   (d_valid),
        .wdt_d_ready   (d_ready),
        .irq_o         (irq),
        .crm_o         (crm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] adr(input int ch, input logic [2:0] r);
        logic [1:0] c;
        c = 2'(ch);
        return {c, r, 2'b00};
    endfunction

    task automatic tl_req(input logic [2:0] op, input int ch, input logic [2:0] r,
                          input logic [31:0] data, input logic [3:0] mask,
                          output logic [31:0] rdata, output logic den, output logic [2:0] dop);
        int n;
        logic [3:0] src;
        @(negedge clk);
        src       = 4'($urandom);
        a_opcode  = op;
        a_address = adr(ch, r);
        a_data    = data;
        a_mask    = mask;
        a_source  = src;
        a_size    = 4'd2;
        a_valid   = 1'b1;
        n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready", a_ready, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        ac = cyc;
        chk("d_valid", d_valid, 1);
        chk("d_source", d_source, src);
        rdata = d_data;
        den   = d_denied;
        dop   = d_opcode;
    endtask

    task automatic put(input int ch, input logic [2:0] r, input logic [31:0] d,
                       input logic [3:0] m, output logic den);
        logic [31:0] x;
        logic [2:0]  o;
        tl_req((m == 4'hF) ? 3'd0 : 3'd1, ch, r, d, m, x, den, o);
        chk("put_opcode", o, 0);
    endtask

    task automatic get(input int ch, input logic [2:0] r, output logic [31:0] d, output logic den);
        logic [2:0] o;
        tl_req(3'd4, ch, r, 32'h0, 4'hF, d, den, o);
        chk("get_opcode", o, 1);
    endtask

    logic [31:0] ld_m [NOC][2];
    logic [31:0] rd;
    logic        den;
    logic [2:0]  op;
    int          b0, last, rise0, rise1, crm_rise, ac_dis, bk, bt, ac_en;

    initial begin
        for (int c = 0; c < NOC; c++) begin
            ld_m[c][0] = 32'h0;
            ld_m[c][1] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset_irq", irq, 0);
        chk("reset_crm", crm, 0);
        get(0, R_COUNT, rd, den);
        chk("reset_count", rd, 0);
        chk("reset_count_den", den, 0);

        for (int it = 0; it < 20; it++) begin
            int          c;
            logic [2:0]  r;
            logic [31:0] d;
            logic [3:0]  m;
            c = $urandom_range(0, NOC - 1);
            r = ($urandom_range(0, 1) == 0) ? R_BARK : R_BITE;
            d = $urandom;
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            put(c, r, d, m, den);
            chk("ld_wr_den", den, (m != 4'hF) ? 1 : 0);
            if (m == 4'hF) ld_m[c][r - R_BARK] = d & 32'hFFFF;
            get(c, r, rd, den);
            chk("ld_rd", rd, ld_m[c][r - R_BARK]);
        end

        get(1, R_PET, rd, den);
        chk("pet_reads_0", rd, 0);
        put(1, R_RSVD, 32'hFFFF_FFFF, 4'hF, den);
        chk("rsvd_wr_den", den, 0);
        get(1, R_RSVD, rd, den);
        chk("rsvd_rd", rd, 0);
        get(3, R_CTRL, rd, den);
        chk("oob_den", den, 1);
        chk("oob_data", rd, 0);

        b0 = $urandom_range(8, 14);
        put(0, R_BARK, b0, 4'hF, den);
        put(0, R_BITE, 200, 4'hF, den);
        put(0, R_CTRL, 1, 4'hF, den);
        last = ac;
        for (int k = 0; k < 6; k++) begin
            int gap;
            gap = (k == 5) ? b0 : $urandom_range(1, b0);
            for (int w = 0; w < gap - 1; w++) begin
                @(negedge clk);
                chk("irq0_petted", irq[0], (cyc >= last + b0 + 1) ? 1 : 0);
            end
            put(0, R_PET, KEY, 4'hF, den);
            chk("pet_den", den, 0);
            last = ac;
        end
        get(0, R_COUNT, rd, den);
        chk("count_live", rd, b0 - (ac - 1 - last));
        put(0, R_PET, 32'h0, 4'hF, den);
        chk("bad_pet_den", den, 1);
        while (!irq[0] && cyc < last + b0 + 30) @(negedge clk);
        chk("irq0_rise", cyc, last + b0 + 1);
        rise0 = cyc;

        put(0, R_CTRL, 3, 4'hF, den);
        chk("lock_den", den, 0);
        get(0, R_CTRL, rd, den);
        chk("lock_rd", rd, 3);
        put(0, R_BARK, 32'h55, 4'hF, den);
        chk("locked_ld_den", den, 1);
        get(0, R_BARK, rd, den);
        chk("locked_ld_rd", rd, b0);
        put(0, R_CTRL, 0, 4'hF, den);
        chk("unlock_den", den, 1);
        put(0, R_CTRL, 2, 4'hF, den);
        chk("locked_dis_den", den, 0);
        ac_dis = ac;
        repeat (3) @(negedge clk);
        get(0, R_COUNT, rd, den);
        chk("dis_count_hold", rd, 200 - (ac_dis - 1 - rise0));
        chk("dis_bark_hold", irq[0], 1);

        put(0, R_STATUS, 1, 4'hF, den);
        chk("w1c_den", den, 0);
        @(negedge clk);
        chk("w1c_irq", irq[0], 0);
        get(0, R_STATUS, rd, den);
        chk("w1c_status", rd, 0);
        put(2, R_BARK, 32'h1234, 4'h3, den);
        chk("partial_den", den, 1);
        get(2, R_BARK, rd, den);
        chk("partial_rd", rd, ld_m[2][0]);

        @(posedge clk);
        #1;
        d_ready = 1'b0;
        get(2, R_BITE, rd, den);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("stall_a_ready", a_ready, 0);
            chk("stall_d_valid", d_valid, 1);
            chk("stall_d_data", d_data, ld_m[2][1]);
            chk("stall_d_opcode", d_opcode, 1);
        end
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_drain", d_valid, 0);

        bk = $urandom_range(0, 6);
        bt = $urandom_range(0, 5);
        put(1, R_BARK, bk, 4'hF, den);
        put(1, R_BITE, bt, 4'hF, den);
        put(1, R_CTRL, 1, 4'hF, den);
        ac_en = ac;
        while (!irq[1] && cyc < ac_en + 40) @(negedge clk);
        chk("irq1_rise", cyc - ac_en, bk + 1);
        rise1 = cyc;
        while (!crm && cyc < rise1 + 40) @(negedge clk);
        crm_rise = cyc;
        chk("crm_rise", crm_rise - rise1, bt + 2);
        get(1, R_STATUS, rd, den);
        chk("exp_status", rd, 3);
        put(1, R_CTRL, 0, 4'hF, den);
        chk("exp_ctrl_den", den, 0);
        put(1, R_PET, KEY, 4'hF, den);
        chk("exp_pet_den", den, 0);
        get(1, R_COUNT, rd, den);
        chk("exp_count", rd, 0);
        chk("exp_crm_sticky", crm, 1);
        chk("exp_irq_sticky", irq, 3'b010);

        @(posedge clk);
        #1;
        d_ready = 1'b0;
        get(1, R_STATUS, rd, den);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_irq", irq, 0);
        chk("async_crm", crm, 0);
        chk("async_d_valid", d_valid, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        d_ready = 1'b1;
        get(1, R_COUNT, rd, den);
        chk("post_rst_count", rd, 0);
        tl_req(3'd2, 0, R_CTRL, 32'h1, 4'hF, rd, den, op);
        chk("bad_op_den", den, 1);
        chk("bad_op_opcode", op, 0);
        get(0, R_CTRL, rd, den);
        chk("bad_op_no_effect", rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
